// File: rtl/ripple_add_seq.sv
// ---------------------------------------------------------------------------
// ripple_add_seq : multi-cycle WIDTH-bit adder built around one 4-bit ripple
// carry adder (ripple_CA). One nibble slice is added per clock, least
// significant slice first; the carry between slices lives in carry_reg.
//
// Optional build macro: RIPPLE_ADD_SEQ_SUB_EN
//   When defined, adds input port 'sub'. sub=1 computes a - b (mod 2^WIDTH)
//   with cout = 1 meaning "no borrow". When undefined, addition only.
//
// Ports (top):
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   operand request valid
//   in_ready   out  block can accept operands (IDLE and not in reset)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in for slice 0
//   sub        in   subtract select (only with RIPPLE_ADD_SEQ_SUB_EN)
//   out_valid  out  result valid (registered)
//   out_ready  in   consumer accepts result
//   sum        out  WIDTH-bit result, held until the next result completes
//   cout       out  carry-out of the top slice
//   busy       out  high while in RUN or DONE (registered)
//
// Ports (ripple_CA):
//   a, b  in 4-bit addends, ci in carry-in, s out 4-bit sum, co out carry-out
// ---------------------------------------------------------------------------

module ripple_CA (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_fa
         assign s[gi]     = a[gi] ^ b[gi] ^ c[gi];
         assign c[gi + 1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

   assign co = c[4];
endmodule

module ripple_add_seq #(
   parameter int WIDTH = 16   // multiple of 4, >= 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef RIPPLE_ADD_SEQ_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);
   localparam int NSLICE = WIDTH / 4;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] slice_cnt_reg;
   logic             carry_reg;
   logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
   logic [WIDTH-1:0] res_sh_reg;     // partial result, fills from the MSB end
   logic [WIDTH-1:0] sum_reg;        // published result, only updated on completion
   logic             cout_reg;
   logic             out_valid_reg;
   logic             busy_reg;

   logic             load;           // operand handshake this edge
   logic             step;           // one slice is added this edge
   logic             last;           // this slice is the top slice
   logic             sub_eff;        // subtract mode for the op being accepted
   logic             sub_reg;        // subtract mode for the op in flight
   logic [3:0]       add_b;
   logic [3:0]       add_s;
   logic             add_co;

`ifdef RIPPLE_ADD_SEQ_SUB_EN
   assign sub_eff = sub;
`else
   assign sub_eff = 1'b0;
`endif

   // Subtraction is a + ~b + 1: invert each B nibble and seed the carry with 1.
   assign add_b = b_sh_reg[3:0] ^ {4{sub_reg}};
   assign last  = (slice_cnt_reg == LAST_SLICE);

   ripple_CA u_adder (
      .a  (a_sh_reg[3:0]),
      .b  (add_b),
      .ci (carry_reg),
      .s  (add_s),
      .co (add_co)
   );

   // Next-state and handshake decode.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      step       = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (in_valid) begin
               state_next = RUN;
               load       = 1'b1;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // State register plus the registered status outputs derived from it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         out_valid_reg <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= (state_next == DONE);
         busy_reg      <= (state_next != IDLE);
      end
   end

   // Datapath: operand shifters, slice counter, carry and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slice_cnt_reg <= '0;
         carry_reg     <= 1'b0;
         a_sh_reg      <= '0;
         b_sh_reg      <= '0;
         res_sh_reg    <= '0;
         sum_reg       <= '0;
         cout_reg      <= 1'b0;
         sub_reg       <= 1'b0;
      end else begin
         if (load) begin
            a_sh_reg      <= a;
            b_sh_reg      <= b;
            carry_reg     <= sub_eff ? 1'b1 : cin;
            sub_reg       <= sub_eff;
            slice_cnt_reg <= '0;
         end else if (step) begin
            a_sh_reg      <= {4'b0000, a_sh_reg[WIDTH-1:4]};
            b_sh_reg      <= {4'b0000, b_sh_reg[WIDTH-1:4]};
            res_sh_reg    <= {add_s, res_sh_reg[WIDTH-1:4]};
            carry_reg     <= add_co;
            slice_cnt_reg <= slice_cnt_reg + 1'b1;
            // The visible result only changes once the whole word is ready,
            // so sum/cout stay at the previous result while RUN is in progress.
            if (last) begin
               sum_reg  <= {add_s, res_sh_reg[WIDTH-1:4]};
               cout_reg <= add_co;
            end
         end
      end
   end

   assign in_ready  = rst_n && (state_reg == IDLE);
   assign out_valid = out_valid_reg;
   assign busy      = busy_reg;
   assign sum       = sum_reg;
   assign cout      = cout_reg;

endmodule

// File: tb/tb_ripple_add_seq.sv
// ---------------------------------------------------------------------------
// tb_ripple_add_seq : self-checking bench for ripple_add_seq (WIDTH=16).
// Expected results come from plain integer arithmetic on the operands.
// Honours RIPPLE_ADD_SEQ_SUB_EN to exercise the subtract option.
// ---------------------------------------------------------------------------

module tb_ripple_add_seq;
   localparam int W      = 16;
   localparam int NSLICE = W / 4;
`ifdef RIPPLE_ADD_SEQ_SUB_EN
   localparam bit HAS_SUB = 1'b1;
`else
   localparam bit HAS_SUB = 1'b0;
`endif

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
`ifdef RIPPLE_ADD_SEQ_SUB_EN
   logic         sub;
`endif
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         busy;

   int vectors;
   int miscompares;

   ripple_add_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef RIPPLE_ADD_SEQ_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {cout,sum} = a + b + cin, or a - b with no-borrow flag.
   function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                        input logic mcin, input logic msub);
      logic [W:0] r;
      if (HAS_SUB && msub)
         r = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
      else
         r = {1'b0, ma} + {1'b0, mb} + (W+1)'(mcin);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ops(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tcin, input logic tsub);
      a   = ta;
      b   = tb_v;
      cin = tcin;
`ifdef RIPPLE_ADD_SEQ_SUB_EN
      sub = tsub;
`else
      if (tsub) $display("note: sub requested without subtract build, ignored");
`endif
   endtask

   // Full transaction from IDLE: accept, measure latency, check, handshake.
   task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic tcin, input logic tsub);
      logic [W:0] exp;
      int lat;
      exp = model(ta, tb_v, tcin, tsub);
      drive_ops(ta, tb_v, tcin, tsub);
      in_valid = 1'b1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL %s idle_in_ready got=%b want=1", name, in_ready);
      end
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      vectors++;
      if (lat != NSLICE) begin
         miscompares++;
         $display("FAIL %s latency got=%0d want=%0d", name, lat, NSLICE);
      end
      vectors++;
      if ({cout, sum} !== exp) begin
         miscompares++;
         $display("FAIL %s result got=%b_%h want=%b_%h", name, cout, sum, exp[W], exp[W-1:0]);
      end
      vectors++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL %s done_flags busy=%b in_ready=%b want busy=1 in_ready=0", name, busy, in_ready);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || {cout, sum} !== exp) begin
         miscompares++;
         $display("FAIL %s after_handshake out_valid=%b busy=%b result=%b_%h want 0 0 %b_%h",
                  name, out_valid, busy, cout, sum, exp[W], exp[W-1:0]);
      end
      $display("op %s a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b lat=%0d", name, ta, tb_v, tcin, tsub,
               sum, cout, lat);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state out_valid=%b busy=%b sum=%h cout=%b in_ready=%b want all 0",
                  out_valid, busy, sum, cout, in_ready);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release in_ready got=%b want=1", in_ready);
      end
      $display("reset checked");
   endtask

   task automatic test_directed();
      run_op("dir_1234_4321", 16'h1234, 16'h4321, 1'b0, 1'b0);
      run_op("dir_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
      run_op("dir_0_0_cin", 16'h0000, 16'h0000, 1'b1, 1'b0);
      run_op("dir_ffff_ffff_cin", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
   endtask

   task automatic test_sub();
      if (HAS_SUB) begin
         run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 1'b1);
         run_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1);
         run_op("sub_eq", 16'hA5A5, 16'hA5A5, 1'b0, 1'b1);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         run_op($sformatf("rand_%0d", i), W'($urandom), W'($urandom), 1'($urandom),
                HAS_SUB ? 1'($urandom) : 1'b0);
      end
   endtask

   // Stall in DONE while new operands are offered; they must wait for IDLE.
   task automatic test_hold();
      logic [W:0] exp1, exp2;
      int lat;
      exp1 = model(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
      exp2 = model(16'h8000, 16'h8000, 1'b1, 1'b0);
      drive_ops(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
      drive_ops(16'h8000, 16'h8000, 1'b1, 1'b0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp1) begin
            miscompares++;
            $display("FAIL hold_%0d out_valid=%b in_ready=%b result=%b_%h want 1 0 %b_%h",
                     i, out_valid, in_ready, cout, sum, exp1[W], exp1[W-1:0]);
         end
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      vectors++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_release in_ready=%b busy=%b out_valid=%b want 1 0 0", in_ready, busy, out_valid);
      end
      tick();
      in_valid = 1'b0;
      vectors++;
      if (busy !== 1'b1 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL hold_accept busy=%b in_ready=%b want 1 0", busy, in_ready);
      end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         tick();
         lat++;
      end
      vectors++;
      if (lat != NSLICE || {cout, sum} !== exp2) begin
         miscompares++;
         $display("FAIL hold_second lat=%0d result=%b_%h want %0d %b_%h",
                  lat, cout, sum, NSLICE, exp2[W], exp2[W-1:0]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      $display("hold op1=%h op2 sum=%h cout=%b", exp1[W-1:0], sum, cout);
   endtask

   // Reset while slice_cnt == 2 must drop the operation entirely.
   task automatic test_reset_mid();
      int seen;
      drive_ops(16'h1111, 16'h2222, 1'b0, 1'b0);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid out_valid=%b busy=%b sum=%h cout=%b in_ready=%b want all 0",
                  out_valid, busy, sum, cout, in_ready);
      end
      rst_n = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_mid_release in_ready got=%b want=1", in_ready);
      end
      seen = 0;
      for (int i = 0; i < NSLICE + 4; i++) begin
         tick();
         if (out_valid === 1'b1 || busy === 1'b1) seen++;
      end
      vectors++;
      if (seen != 0) begin
         miscompares++;
         $display("FAIL reset_mid_stale activity_cycles got=%0d want=0", seen);
      end
      $display("reset_mid checked");
   endtask

   // in_valid held high, out_ready high: throughput and ordering.
   task automatic test_back_to_back();
      logic [W:0] expq[$];
      int acc_cyc[$];
      int results;
      logic [W:0] e;
      logic acc_now, out_now;
      results = 0;
      out_ready = 1'b1;
      drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      in_valid = 1'b1;
      for (int cyc = 0; cyc < 200 && results < 5; cyc++) begin
         acc_now = in_ready && in_valid;
         out_now = out_valid && out_ready;
         if (acc_now) begin
            expq.push_back(model(a, b, cin, 1'b0));
            acc_cyc.push_back(cyc);
         end
         if (out_now) begin
            vectors++;
            if (expq.size() == 0) begin
               miscompares++;
               $display("FAIL b2b_unexpected_result sum=%h want none", sum);
            end else begin
               e = expq.pop_front();
               if ({cout, sum} !== e) begin
                  miscompares++;
                  $display("FAIL b2b_result_%0d got=%b_%h want=%b_%h", results, cout, sum, e[W], e[W-1:0]);
               end
            end
            $display("b2b result %0d sum=%h cout=%b", results, sum, cout);
            results++;
         end
         tick();
         if (acc_now) drive_ops(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      end
      in_valid = 1'b0;
      vectors++;
      if (results != 5) begin
         miscompares++;
         $display("FAIL b2b_count got=%0d want=5", results);
      end
      for (int i = 1; i < acc_cyc.size(); i++) begin
         vectors++;
         if (acc_cyc[i] - acc_cyc[i-1] != NSLICE + 2) begin
            miscompares++;
            $display("FAIL b2b_spacing_%0d got=%0d want=%0d", i, acc_cyc[i] - acc_cyc[i-1], NSLICE + 2);
         end
      end
      // Drain whatever was accepted after the last counted result.
      repeat (NSLICE + 3) tick();
      out_ready = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      out_ready   = 1'b0;
      a           = '0;
      b           = '0;
      cin         = 1'b0;
`ifdef RIPPLE_ADD_SEQ_SUB_EN
      sub         = 1'b0;
`endif
      test_reset();
      test_directed();
      test_sub();
      test_random();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
